// File: rtl/time_sync_scheduler.sv
// time_sync_scheduler
// Sequences the network time-sync engine: takes manual (and optionally
// periodic) requests, starts the engine, waits with a per-attempt timeout
// and bounded retries, and hands a successful result to the clock datapath
// as a one-cycle set pulse with a 64-bit time word.
// Optional feature: define SYNC_AUTO_EN to build the periodic auto-sync
// timer; without it only manual key edges start a sync.
module time_sync_scheduler #(
    parameter int TICK_DIV       = 100000000,
`ifdef SYNC_AUTO_EN
    parameter int SYNC_PERIOD_S  = 3600,
`endif
    parameter int WAIT_TIMEOUT_S = 5,
    parameter int MAX_RETRY      = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_manual_req,
    input  logic        i_cancel_req,
    input  logic        i_sync_finished,
    input  logic [31:0] i_sync_time,
    output logic        o_sync_en,
    output logic        o_set_time_valid,
    output logic [63:0] o_set_time,
    output logic        o_busy,
    output logic        o_sync_ok,
    output logic [7:0]  o_fail_cnt,
    output logic [2:0]  o_state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    localparam int WW = (WAIT_TIMEOUT_S > 1) ? $clog2(WAIT_TIMEOUT_S + 1) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_TIMEOUT_S - 1);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_GAP   = 3'd4,
        ST_FAIL  = 3'd5
    } stateT;

    stateT          r_state;
    stateT          w_nextState;
    logic [PW-1:0]  r_prescale;
    logic [WW-1:0]  r_waitCnt;
    logic [RW-1:0]  r_retryCnt;
    logic           r_prevManual;
    logic           r_prevCancel;
    logic [31:0]    r_setTime;
    logic           r_syncOk;
    logic [7:0]     r_failCnt;

    logic           w_tick;
    logic           w_manualEdge;
    logic           w_cancelEdge;
    logic           w_startReq;
    logic           w_timeout;
    logic           w_retryInc;
    logic           w_loadTime;

    assign w_tick       = (r_prescale == PRE_LAST);
    assign w_manualEdge = i_manual_req & ~r_prevManual;
    assign w_cancelEdge = i_cancel_req & ~r_prevCancel;
    assign w_timeout    = (r_state == ST_WAIT) && w_tick && (r_waitCnt == WAIT_LAST);

    // Free-running prescaler producing the one-second tick
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_prescale <= '0;
        end else if (w_tick) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + PW'(1);
        end
    end

    // Previous key levels, kept in every state so edges are never stale
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_prevManual <= 1'b0;
            r_prevCancel <= 1'b0;
        end else begin
            r_prevManual <= i_manual_req;
            r_prevCancel <= i_cancel_req;
        end
    end

`ifdef SYNC_AUTO_EN
    localparam int CW = (SYNC_PERIOD_S > 1) ? $clog2(SYNC_PERIOD_S + 1) : 1;
    localparam logic [CW-1:0] PERIOD_LAST = CW'(SYNC_PERIOD_S - 1);

    logic [CW-1:0] r_periodCnt;
    logic          w_autoReq;

    assign w_autoReq  = (r_state == ST_IDLE) && w_tick && (r_periodCnt == PERIOD_LAST);
    assign w_startReq = w_manualEdge | w_autoReq;

    // Seconds spent idle; held at zero outside IDLE so every IDLE entry restarts the period
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_periodCnt <= '0;
        end else if (r_state != ST_IDLE) begin
            r_periodCnt <= '0;
        end else if (w_tick) begin
            r_periodCnt <= r_periodCnt + CW'(1);
        end
    end
`else
    assign w_startReq = w_manualEdge;
`endif

    // Seconds spent waiting for the engine in the current attempt
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_waitCnt <= '0;
        end else if (r_state == ST_START) begin
            r_waitCnt <= '0;
        end else if ((r_state == ST_WAIT) && w_tick) begin
            r_waitCnt <= r_waitCnt + WW'(1);
        end
    end

    // Retries used by the current request; a fresh request starts from zero
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_retryCnt <= '0;
        end else if ((r_state == ST_IDLE) && w_startReq) begin
            r_retryCnt <= '0;
        end else if (w_retryInc) begin
            r_retryCnt <= r_retryCnt + RW'(1);
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; in WAIT a finished result beats cancel, which beats timeout
    always_comb begin
        w_nextState = r_state;
        w_retryInc  = 1'b0;
        w_loadTime  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_startReq) begin
                    w_nextState = ST_START;
                end
            end
            ST_START: begin
                w_nextState = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_sync_finished) begin
                    w_loadTime  = 1'b1;
                    w_nextState = ST_DONE;
                end else if (w_cancelEdge) begin
                    w_nextState = ST_IDLE;
                end else if (w_timeout) begin
                    if (r_retryCnt < RETRY_MAX) begin
                        w_retryInc  = 1'b1;
                        w_nextState = ST_GAP;
                    end else begin
                        w_nextState = ST_FAIL;
                    end
                end
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            ST_GAP: begin
                if (w_cancelEdge) begin
                    w_nextState = ST_IDLE;
                end else if (w_tick) begin
                    w_nextState = ST_START;
                end
            end
            ST_FAIL: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Result registers: latched time, last outcome, saturating failure count
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_setTime <= '0;
            r_syncOk  <= 1'b0;
            r_failCnt <= '0;
        end else begin
            if (w_loadTime) begin
                r_setTime <= i_sync_time;
            end
            if (r_state == ST_DONE) begin
                r_syncOk <= 1'b1;
            end
            if (r_state == ST_FAIL) begin
                r_syncOk <= 1'b0;
                if (r_failCnt != 8'hFF) begin
                    r_failCnt <= r_failCnt + 8'd1;
                end
            end
        end
    end

    assign o_sync_en        = (r_state == ST_START);
    assign o_set_time_valid = (r_state == ST_DONE);
    assign o_set_time       = {32'b0, r_setTime};
    assign o_busy           = (r_state != ST_IDLE);
    assign o_sync_ok        = r_syncOk;
    assign o_fail_cnt       = r_failCnt;
    assign o_state          = r_state;

endmodule

// File: tb/tb_time_sync_scheduler.sv
// Testbench for time_sync_scheduler: directed scenarios with literal
// expectations plus randomized key/engine activity, all checked every cycle
// against a behavioural model of the scheduler.
module tb_time_sync_scheduler;

    localparam int TD = 10;
    localparam int WT = 3;
    localparam int MR = 2;
`ifdef SYNC_AUTO_EN
    localparam int SP = 5;
`endif

    localparam int P_IDLE  = 0;
    localparam int P_START = 1;
    localparam int P_WAIT  = 2;
    localparam int P_DONE  = 3;
    localparam int P_GAP   = 4;
    localparam int P_FAIL  = 5;

    logic        clk   = 1'b0;
    logic        rn    = 1'b0;
    logic        man   = 1'b0;
    logic        can   = 1'b0;
    logic        fin   = 1'b0;
    logic [31:0] stime = '0;

    logic        sEn;
    logic        stv;
    logic [63:0] sTime;
    logic        busy;
    logic        ok;
    logic [7:0]  fcnt;
    logic [2:0]  st;

    time_sync_scheduler #(
        .TICK_DIV(TD),
`ifdef SYNC_AUTO_EN
        .SYNC_PERIOD_S(SP),
`endif
        .WAIT_TIMEOUT_S(WT),
        .MAX_RETRY(MR)
    ) dut (
        .i_clk(clk),
        .i_reset_n(rn),
        .i_manual_req(man),
        .i_cancel_req(can),
        .i_sync_finished(fin),
        .i_sync_time(stime),
        .o_sync_en(sEn),
        .o_set_time_valid(stv),
        .o_set_time(sTime),
        .o_busy(busy),
        .o_sync_ok(ok),
        .o_fail_cnt(fcnt),
        .o_state(st)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cycleNo  = 0;
    int enSeen   = 0;
    int stvSeen  = 0;
    int dutEnReq = 0;
    int enTimes[$];

    // Behavioural model: seconds since reset from a cycle count, phase code, counters
    int          mPhase;
    int          mCycle;
    int          mWaitTicks;
    int          mRetries;
    bit          mPrevMan;
    bit          mPrevCan;
    logic [63:0] mSetTime;
    bit          mOk;
    int          mFail;
`ifdef SYNC_AUTO_EN
    int          mIdleTicks;
`endif

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycleNo);
        end
    endtask

    task goIdle();
        mPhase = P_IDLE;
`ifdef SYNC_AUTO_EN
        mIdleTicks = 0;
`endif
    endtask

    task modelStep();
        bit tick;
        bit mEdge;
        bit cEdge;
        bit req;
        if (!rn) begin
            mCycle = 0; mWaitTicks = 0; mRetries = 0;
            mPrevMan = 0; mPrevCan = 0; mSetTime = '0; mOk = 0; mFail = 0;
            goIdle();
            return;
        end
        tick  = ((mCycle % TD) == TD - 1);
        mEdge = man && !mPrevMan;
        cEdge = can && !mPrevCan;
        req   = mEdge;
`ifdef SYNC_AUTO_EN
        if (mPhase == P_IDLE && tick && mIdleTicks == SP - 1) req = 1;
`endif
        case (mPhase)
            P_IDLE: begin
`ifdef SYNC_AUTO_EN
                if (tick) mIdleTicks++;
`endif
                if (req) begin
                    mPhase = P_START;
                    mRetries = 0;
                end
            end
            P_START: begin
                mWaitTicks = 0;
                mPhase = P_WAIT;
            end
            P_WAIT: begin
                if (fin) begin
                    mSetTime = {32'b0, stime};
                    mPhase = P_DONE;
                end else if (cEdge) begin
                    goIdle();
                end else if (tick) begin
                    if (mWaitTicks == WT - 1) begin
                        if (mRetries < MR) begin
                            mRetries++;
                            mPhase = P_GAP;
                        end else begin
                            mPhase = P_FAIL;
                        end
                    end else begin
                        mWaitTicks++;
                    end
                end
            end
            P_GAP: begin
                if (cEdge) goIdle();
                else if (tick) mPhase = P_START;
            end
            P_DONE: begin
                mOk = 1;
                goIdle();
            end
            default: begin
                mOk = 0;
                if (mFail < 255) mFail++;
                goIdle();
            end
        endcase
        mPrevMan = man;
        mPrevCan = can;
        mCycle++;
    endtask

    task compareAll();
        checkOutput("state", 64'(st), 64'(mPhase));
        checkOutput("syncEn", 64'(sEn), 64'(mPhase == P_START));
        checkOutput("setValid", 64'(stv), 64'(mPhase == P_DONE));
        checkOutput("busy", 64'(busy), 64'(mPhase != P_IDLE));
        checkOutput("setTime", sTime, mSetTime);
        checkOutput("syncOk", 64'(ok), 64'(mOk));
        checkOutput("failCnt", 64'(fcnt), 64'(mFail));
        if (st == 3'd0) dutEnReq = 0;
        if (sEn === 1'b1) begin
            enSeen++;
            enTimes.push_back(cycleNo);
            dutEnReq++;
            checkOutput("enPerRequestBound", 64'(dutEnReq <= 1 + MR), 64'd1);
        end
        if (stv === 1'b1) stvSeen++;
    endtask

    task applyStimulus(input logic m, input logic c, input logic f, input logic [31:0] t);
        man = m; can = c; fin = f; stime = t;
        @(posedge clk);
        modelStep();
        #1;
        cycleNo++;
        compareAll();
    endtask

    task doReset();
        rn = 1'b0;
        applyStimulus(0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0);
        rn = 1'b1;
    endtask

    initial begin
        int n;
        int firstIdx;
        int gap;
        bit spacingOk;

        // Reset state
        doReset();
        checkOutput("rstState", 64'(st), 64'd0);
        checkOutput("rstSetTime", sTime, 64'd0);
        checkOutput("rstBusy", 64'(busy), 64'd0);
        checkOutput("rstSyncOk", 64'(ok), 64'd0);
        checkOutput("rstFailCnt", 64'(fcnt), 64'd0);
        checkOutput("rstSyncEn", 64'(sEn), 64'd0);

        // Manual request, successful result
        stvSeen = 0;
        applyStimulus(1, 0, 0, 32'h0);
        checkOutput("t1SyncEn", 64'(sEn), 64'd1);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("t1InWait", 64'(st), 64'd2);
        applyStimulus(0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0);
        applyStimulus(0, 0, 1, 32'h12345678);
        checkOutput("t1Valid", 64'(stv), 64'd1);
        checkOutput("t1SetTime", sTime, 64'h0000000012345678);
        applyStimulus(0, 0, 0, 32'hDEADBEEF);
        checkOutput("t1ValidOneCycle", 64'(stv), 64'd0);
        checkOutput("t1SyncOk", 64'(ok), 64'd1);
        checkOutput("t1BusyLow", 64'(busy), 64'd0);
        checkOutput("t1TimeHeld", sTime, 64'h0000000012345678);
        checkOutput("t1ValidCount", 64'(stvSeen), 64'd1);

        // No result: three attempts then failure
        enSeen = 0; stvSeen = 0; enTimes.delete();
        applyStimulus(1, 0, 0, 32'h0);
        n = 0;
        while (st != 3'd0 && n < 300) begin
            applyStimulus(0, 0, 0, 32'h0);
            n++;
        end
        checkOutput("t2ReturnedIdle", 64'(st), 64'd0);
        checkOutput("t2EnCount", 64'(enSeen), 64'd3);
        spacingOk = 0;
        if (enTimes.size() >= 2) begin
            gap = enTimes[1] - enTimes[0];
            spacingOk = (gap >= 30 && gap <= 45);
        end
        checkOutput("t2Spacing", 64'(spacingOk), 64'd1);
        checkOutput("t2FailCnt", 64'(fcnt), 64'd1);
        checkOutput("t2SyncOk", 64'(ok), 64'd0);
        checkOutput("t2NoValid", 64'(stvSeen), 64'd0);

        // Cancel in WAIT, then a late result
        stvSeen = 0;
        applyStimulus(1, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0);
        applyStimulus(0, 1, 0, 32'h0);
        checkOutput("t3CancelIdle", 64'(st), 64'd0);
        applyStimulus(0, 1, 1, 32'hCAFEF00D);
        applyStimulus(0, 0, 1, 32'hCAFEF00D);
        checkOutput("t3NoValid", 64'(stvSeen), 64'd0);
        checkOutput("t3FailCnt", 64'(fcnt), 64'd1);
        checkOutput("t3TimeHeld", sTime, 64'h0000000012345678);

        // Result and cancel in the same cycle: result wins
        applyStimulus(0, 0, 0, 32'h0);
        applyStimulus(1, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0);
        applyStimulus(0, 1, 1, 32'hA5A50001);
        checkOutput("t4Valid", 64'(stv), 64'd1);
        checkOutput("t4SetTime", sTime, 64'h00000000A5A50001);
        applyStimulus(0, 0, 0, 32'h0);
        checkOutput("t4SyncOk", 64'(ok), 64'd1);

        // Idle from reset: periodic request or none
        doReset();
        enSeen = 0;
        firstIdx = -1;
        for (int i = 1; i <= 500 && firstIdx < 0; i++) begin
            applyStimulus(0, 0, 0, 32'h0);
            if (sEn === 1'b1) firstIdx = i;
        end
`ifdef SYNC_AUTO_EN
        checkOutput("t5AutoWindow", 64'(firstIdx >= 50 && firstIdx <= 60), 64'd1);
`else
        checkOutput("t5NoAuto", 64'(enSeen), 64'd0);
`endif

        // Reset during WAIT, then a result
        doReset();
        stvSeen = 0;
        applyStimulus(1, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0);
        rn = 1'b0;
        applyStimulus(0, 0, 0, 32'h0);
        rn = 1'b1;
        applyStimulus(0, 0, 1, 32'h11112222);
        checkOutput("t6State", 64'(st), 64'd0);
        checkOutput("t6SetTime", sTime, 64'd0);
        checkOutput("t6Busy", 64'(busy), 64'd0);
        checkOutput("t6SyncOk", 64'(ok), 64'd0);
        checkOutput("t6FailCnt", 64'(fcnt), 64'd0);
        checkOutput("t6SyncEn", 64'(sEn), 64'd0);
        checkOutput("t6NoValid", 64'(stvSeen), 64'd0);

        // Randomized key, cancel, engine and reset activity
        for (int i = 0; i < 4000; i++) begin
            logic m;
            logic c;
            logic f;
            m = ($urandom_range(29) == 0) ? ~man : man;
            c = ($urandom_range(59) == 0) ? ~can : can;
            f = ($urandom_range(24) == 0);
            rn = ($urandom_range(999) == 0) ? 1'b0 : 1'b1;
            applyStimulus(m, c, f, $urandom);
        end
        rn = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
